// File: rtl/alu_muldiv_seq.sv
// Purpose: iterative unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared 32-bit ALU for its add/sub steps.
// Latency: done 33 cycles after the accepting edge (32 steps + FIN); divide-by-zero finishes in 1 cycle.
// Backpressure: busy stalls the pipeline; start is ignored unless IDLE; flush aborts without a done pulse.
module alu_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_operand1,
    output logic [XLEN-1:0] alu_operand2,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    // hi_q doubles as the remainder and lo_q as the quotient; opb_q holds multiplicand or divisor.
    logic [1:0]      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] div_t;
    logic            div_ov;
    logic            div_take;
    logic            mul_carry;

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_FIN);
    assign result = result_q;

    // Shifted partial remainder and the local 33rd-bit carry/overflow terms.
    assign div_t     = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign div_ov    = hi_q[XLEN-1];
    assign div_take  = div_ov || (div_t >= opb_q);
    assign mul_carry = (alu_result < hi_q);

    // ALU drive: purely from current state so the step consumes same-cycle ALU output.
    always_comb begin
        alu_operand1 = '0;
        alu_operand2 = '0;
        alu_op       = ALU_ADD;
        if (state_q == S_MUL) begin
            alu_operand1 = hi_q;
            alu_operand2 = opb_q;
            alu_op       = ALU_ADD;
        end else if (state_q == S_DIV) begin
            alu_operand1 = div_t;
            alu_operand2 = opb_q;
            alu_op       = ALU_SUB;
        end
    end

    // Next-state: operand latch, shift-add / restoring steps, result load, flush abort.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    opb_d = b;
                    if (!op[1]) begin
                        hi_d    = '0;
                        lo_d    = b;
                        opb_d   = a;
                        state_d = S_MUL;
                    end else if (b != '0) begin
                        hi_d    = '0;
                        lo_d    = a;
                        state_d = S_DIV;
                    end else begin
                        result_d = (op == OP_DIVU) ? '1 : a;
                        state_d  = S_FIN;
                    end
                end
            end
            S_MUL: begin
                if (lo_q[0]) begin
                    hi_d = {mul_carry, alu_result[XLEN-1:1]};
                    lo_d = {alu_result[0], lo_q[XLEN-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[XLEN-1:1]};
                    lo_d = {hi_q[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = (op_q == OP_MUL) ? lo_d : hi_d;
                    state_d  = S_FIN;
                end
            end
            S_DIV: begin
                if (div_take) begin
                    hi_d = alu_result;
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = div_t;
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    result_d = (op_q == OP_DIVU) ? lo_d : hi_d;
                    state_d  = S_FIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort wins over a final step so result keeps its previous value.
        if (flush && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // OP_MULHU kept for readability of the op encoding.
    logic unused_opcode;
    assign unused_opcode = ^OP_MULHU;

endmodule
